// File: rtl/rat_controller_pkg.sv
// Shared types and constants for the maze-solver control FSM:
// state encoding, direction codes and the move-select bundle.
package rat_controller_pkg;

  localparam int STEP_W_DEFAULT = 10;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_INIT  = 4'd1,
    ST_MARK  = 4'd2,
    ST_TRY   = 4'd3,
    ST_MOVE  = 4'd4,
    ST_BACK  = 4'd5,
    ST_POPMV = 4'd6,
    ST_DONE  = 4'd7,
    ST_FAIL  = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  // Datapath move-select lines produced for one direction.
  typedef struct packed {
    logic adder_sel;
    logic inc_dec_sel;
    logic x_sel;
    logic y_sel;
  } move_sel_t;

  // The encoding is chosen so that bit inversion gives the reverse move.
  function automatic dir_e opposite_dir(input dir_e d);
    return dir_e'(~d);
  endfunction

endpackage

// File: rtl/rat_controller_if.sv
// Bundle of the start/done handshake and the datapath control/status
// lines seen by the maze-solver controller.
interface rat_controller_if
  import rat_controller_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEFAULT
) ();

  // top-level handshake
  logic              start;
  logic              busy;
  logic              done;
  logic              fail;
  logic [STEP_W-1:0] steps;

  // datapath status
  logic       co;
  logic [1:0] counter_val;
  logic [1:0] pop_val;
  logic       empty;
  logic       wall;
  logic       finish;

  // datapath control
  logic       rst_reg;
  logic       rst_counter;
  logic       ld_reg;
  logic       ld_counter;
  logic       adder_sel;
  logic       inc_dec_sel;
  logic       x_sel;
  logic       y_sel;
  logic       rd_mem;
  logic       wr_mem;
  logic       mem_din;
  logic       push;
  logic       pop;
  logic [1:0] push_val;

  // controller side
  modport master (
    input  start, co, counter_val, pop_val, empty, wall, finish,
    output busy, done, fail, steps,
    output rst_reg, rst_counter, ld_reg, ld_counter,
    output adder_sel, inc_dec_sel, x_sel, y_sel,
    output rd_mem, wr_mem, mem_din, push, pop, push_val
  );

  // datapath / top-level side
  modport slave (
    output start, co, counter_val, pop_val, empty, wall, finish,
    input  busy, done, fail, steps,
    input  rst_reg, rst_counter, ld_reg, ld_counter,
    input  adder_sel, inc_dec_sel, x_sel, y_sel,
    input  rd_mem, wr_mem, mem_din, push, pop, push_val
  );

endinterface

// File: rtl/rat_controller_dir_decoder.sv
// Maps a 2-bit direction onto the datapath move-select lines.
module rat_controller_dir_decoder
  import rat_controller_pkg::*;
(
  input  dir_e      dir_i,
  output move_sel_t sel_o
);

  // Pure lookup: up/down act on y, right/left act on x.
  always_comb begin
    sel_o = '0;
    unique case (dir_i)
      DIR_UP:    begin sel_o.y_sel = 1'b1; end
      DIR_RIGHT: begin sel_o.adder_sel = 1'b1; sel_o.inc_dec_sel = 1'b1; sel_o.x_sel = 1'b1; end
      DIR_LEFT:  begin sel_o.adder_sel = 1'b1; sel_o.x_sel = 1'b1; end
      DIR_DOWN:  begin sel_o.inc_dec_sel = 1'b1; sel_o.y_sel = 1'b1; end
      default:   sel_o = '0;
    endcase
  end

endmodule

// File: rtl/rat_controller.sv
// Depth-first maze-search controller. Marks each entered cell visited,
// tries the four directions in order, and backtracks through the
// datapath stack when every neighbour is blocked.
module rat_controller
  import rat_controller_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  rat_controller_if.master bus
);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] steps_inc;

  dir_e      try_dir;
  dir_e      back_dir;
  move_sel_t try_sel;
  move_sel_t back_sel;
  move_sel_t sel;

  logic rst_reg, rst_counter, ld_reg, ld_counter;
  logic rd_mem, wr_mem, mem_din, push, pop;
  logic [1:0] push_val;
  logic busy, done, fail;

  // Forward moves use the direction under test; backtracks reverse the popped one.
  assign try_dir  = dir_e'(bus.counter_val);
  assign back_dir = opposite_dir(dir_e'(bus.pop_val));

  rat_controller_dir_decoder u_dec_try (
    .dir_i (try_dir),
    .sel_o (try_sel)
  );

  rat_controller_dir_decoder u_dec_back (
    .dir_i (back_dir),
    .sel_o (back_sel)
  );

  // Step counter holds at all-ones instead of wrapping.
  assign steps_inc = (&steps_q) ? steps_q : steps_q + 1'b1;

  // State and step counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
    end
  end

  // Next-state logic and every datapath control line.
  always_comb begin
    state_d     = state_q;
    steps_d     = steps_q;
    sel         = '0;
    rst_reg     = 1'b0;
    rst_counter = 1'b0;
    ld_reg      = 1'b0;
    ld_counter  = 1'b0;
    rd_mem      = 1'b0;
    wr_mem      = 1'b0;
    mem_din     = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    push_val    = 2'b00;
    busy        = 1'b0;
    done        = 1'b0;
    fail        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_INIT;
          steps_d = '0;
        end
      end
      ST_INIT: begin
        busy        = 1'b1;
        rst_reg     = 1'b1;
        rst_counter = 1'b1;
        state_d     = ST_MARK;
      end
      ST_MARK: begin
        // select lines stay 0 so the write lands on the current cell
        busy    = 1'b1;
        wr_mem  = 1'b1;
        mem_din = 1'b1;
        state_d = bus.finish ? ST_DONE : ST_TRY;
      end
      ST_TRY: begin
        busy   = 1'b1;
        sel    = try_sel;
        rd_mem = 1'b1;
        if (!bus.wall) begin
          state_d = ST_MOVE;
        end else if (bus.co) begin
          state_d = ST_BACK;
        end else begin
          ld_counter = 1'b1;
        end
      end
      ST_MOVE: begin
        busy        = 1'b1;
        sel         = try_sel;
        ld_reg      = 1'b1;
        push        = 1'b1;
        push_val    = bus.counter_val;
        rst_counter = 1'b1;
        steps_d     = steps_inc;
        state_d     = ST_MARK;
      end
      ST_BACK: begin
        busy = 1'b1;
        if (bus.empty) begin
          state_d = ST_FAIL;
        end else begin
          pop     = 1'b1;
          state_d = ST_POPMV;
        end
      end
      ST_POPMV: begin
        // parent cell was marked when first entered, so go straight to TRY
        busy        = 1'b1;
        sel         = back_sel;
        ld_reg      = 1'b1;
        rst_counter = 1'b1;
        steps_d     = steps_inc;
        state_d     = ST_TRY;
      end
      ST_DONE: begin
        done = 1'b1;
        if (!bus.start) state_d = ST_IDLE;
      end
      ST_FAIL: begin
        fail = 1'b1;
        if (!bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.rst_reg     = rst_reg;
  assign bus.rst_counter = rst_counter;
  assign bus.ld_reg      = ld_reg;
  assign bus.ld_counter  = ld_counter;
  assign bus.adder_sel   = sel.adder_sel;
  assign bus.inc_dec_sel = sel.inc_dec_sel;
  assign bus.x_sel       = sel.x_sel;
  assign bus.y_sel       = sel.y_sel;
  assign bus.rd_mem      = rd_mem;
  assign bus.wr_mem      = wr_mem;
  assign bus.mem_din     = mem_din;
  assign bus.push        = push;
  assign bus.pop         = pop;
  assign bus.push_val    = push_val;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.fail        = fail;
  assign bus.steps       = steps_q;

endmodule

// File: tb/tb_rat_controller.sv
// Bench for rat_controller: a behavioural datapath (maze, position,
// direction counter, stack) closes the loop around the controller, and
// a plain DFS model predicts outcome, step count, stack traffic and
// busy-cycle count for directed and random mazes.
`timescale 1ns/1ps
module tb_rat_controller;

  localparam int RUN_BOUND = 8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rat_controller_if #(.STEP_W(10)) bus ();
  rat_controller_if #(.STEP_W(4))  bus4 ();

  rat_controller #(.STEP_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Narrow-counter copy runs in lockstep off the same datapath.
  rat_controller #(.STEP_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // ---------------- behavioural datapath ----------------
  bit   maze_wall [256];   // cell(x,y) at index y*16+x, 1 = wall
  bit   visited   [256];
  int   stk       [256];
  int   px = 0, py = 0, cnt = 0, sp = 0;
  int   push_cnt = 0, pop_cnt = 0, last_pop = -1;
  logic [1:0] pop_q = 2'b00;
  logic dp_clr = 1'b0;
  int   ax, ay;
  logic wall_c;

  always_comb begin
    ax = px;
    ay = py;
    if (bus.x_sel) ax = bus.inc_dec_sel ? px + 1 : px - 1;
    if (bus.y_sel) ay = bus.inc_dec_sel ? py + 1 : py - 1;
  end

  always_comb begin
    wall_c = 1'b1;
    if (ax >= 0 && ax < 16 && ay >= 0 && ay < 16)
      wall_c = maze_wall[ay*16+ax] | visited[ay*16+ax];
  end

  always @(posedge clk) begin
    if (dp_clr) begin
      for (int i = 0; i < 256; i++) visited[i] <= 1'b0;
      push_cnt <= 0;
      pop_cnt  <= 0;
      last_pop <= -1;
    end else begin
      if (bus.wr_mem && ax >= 0 && ax < 16 && ay >= 0 && ay < 16)
        visited[ay*16+ax] <= bus.mem_din;
      if (bus.push && sp < 256) begin
        stk[sp]  <= int'(bus.push_val);
        push_cnt <= push_cnt + 1;
      end
      if (bus.pop && sp > 0) begin
        pop_q    <= 2'(stk[sp-1]);
        last_pop <= stk[sp-1];
        pop_cnt  <= pop_cnt + 1;
      end
    end
    if (bus.rst_reg) begin
      px <= 0; py <= 0; sp <= 0;
    end else begin
      if (bus.ld_reg) begin
        if (bus.adder_sel) px <= (bus.inc_dec_sel ? px + 1 : px - 1) & 15;
        else               py <= (bus.inc_dec_sel ? py + 1 : py - 1) & 15;
      end
      if (bus.push && sp < 256)    sp <= sp + 1;
      else if (bus.pop && sp > 0)  sp <= sp - 1;
    end
    if (bus.rst_counter)     cnt <= 0;
    else if (bus.ld_counter) cnt <= (cnt + 1) % 4;
  end

  assign bus.co          = (cnt == 3);
  assign bus.counter_val = 2'(cnt);
  assign bus.pop_val     = pop_q;
  assign bus.empty       = (sp == 0);
  assign bus.wall        = wall_c;
  assign bus.finish      = (px == 15 && py == 15);

  assign bus4.start       = bus.start;
  assign bus4.co          = bus.co;
  assign bus4.counter_val = bus.counter_val;
  assign bus4.pop_val     = bus.pop_val;
  assign bus4.empty       = bus.empty;
  assign bus4.wall        = bus.wall;
  assign bus4.finish      = bus.finish;

  logic [17:0] outs;
  assign outs = {bus.rst_reg, bus.rst_counter, bus.ld_reg, bus.ld_counter,
                 bus.adder_sel, bus.inc_dec_sel, bus.x_sel, bus.y_sel,
                 bus.rd_mem, bus.wr_mem, bus.mem_din, bus.push, bus.pop,
                 bus.push_val, bus.busy, bus.done, bus.fail};

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plain DFS over the maze; also tallies the cycle cost of each action.
  task automatic ref_solve(output bit r_done, output int r_steps, output int r_push,
                           output int r_pop, output int r_cyc);
    bit seen [256];
    int trail [$];
    int dx [4] = '{0, 1, -1, 0};
    int dy [4] = '{-1, 0, 0, 1};
    int x, y, nx, ny, dsel;
    bit found;
    bit active;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    x = 0; y = 0; dsel = 0;
    r_done = 1'b0; r_steps = 0; r_push = 0; r_pop = 0;
    r_cyc = 1;                                  // INIT
    active = 1'b1;
    while (active) begin
      seen[y*16+x] = 1'b1;
      r_cyc++;                                  // mark
      if (x == 15 && y == 15) begin
        r_done = 1'b1;
        active = 1'b0;
      end else begin
        found = 1'b0;
        while (!found && active) begin
          for (int d = 0; d < 4 && !found; d++) begin
            nx = x + dx[d];
            ny = y + dy[d];
            r_cyc++;                            // one look per direction
            if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 &&
                !maze_wall[ny*16+nx] && !seen[ny*16+nx]) begin
              found = 1'b1;
              dsel  = d;
            end
          end
          if (!found) begin
            r_cyc++;                            // stack check
            if (trail.size() == 0) begin
              active = 1'b0;
            end else begin
              dsel = trail.pop_back();
              x = x - dx[dsel];
              y = y - dy[dsel];
              r_steps++; r_pop++; r_cyc++;      // step back
            end
          end
        end
        if (found) begin
          trail.push_back(dsel);
          x = x + dx[dsel];
          y = y + dy[dsel];
          r_steps++; r_push++; r_cyc++;         // step forward
        end
      end
    end
  endtask

  task automatic load_all(input bit v);
    for (int i = 0; i < 256; i++) maze_wall[i] = v;
  endtask

  // Open only column x=0 and row y=15.
  task automatic load_maze_a();
    load_all(1'b1);
    for (int i = 0; i < 16; i++) begin
      maze_wall[i*16]      = 1'b0;
      maze_wall[15*16 + i] = 1'b0;
    end
  endtask

  task automatic clear_dp();
    @(negedge clk);
    dp_clr = 1'b1;
    @(negedge clk);
    dp_clr = 1'b0;
  endtask

  task automatic run_one(input string tag, output int n_busy);
    bit timed_out;
    int both;
    clear_dp();
    bus.start = 1'b1;
    n_busy = 0; both = 0; timed_out = 1'b1;
    for (int c = 0; c < RUN_BOUND; c++) begin
      @(posedge clk); #1;
      if (bus.done && bus.fail) both++;
      if (bus.busy) begin
        if (n_busy == 0) check({tag, ".steps_at_init"}, int'(bus.steps), 0);
        n_busy++;
      end
      if (bus.done || bus.fail) begin
        timed_out = 1'b0;
        break;
      end
    end
    check({tag, ".timeout"}, int'(timed_out), 0);
    check({tag, ".done_and_fail"}, both, 0);
  endtask

  task automatic verify_run(input string tag);
    bit r_done;
    int r_steps, r_push, r_pop, r_cyc, n_busy;
    ref_solve(r_done, r_steps, r_push, r_pop, r_cyc);
    run_one(tag, n_busy);
    check({tag, ".done"},   int'(bus.done),  int'(r_done));
    check({tag, ".fail"},   int'(bus.fail),  int'(!r_done));
    check({tag, ".steps"},  int'(bus.steps), (r_steps > 1023) ? 1023 : r_steps);
    check({tag, ".steps4"}, int'(bus4.steps), (r_steps > 15) ? 15 : r_steps);
    check({tag, ".done4"},  int'(bus4.done), int'(r_done));
    check({tag, ".pushes"}, push_cnt, r_push);
    check({tag, ".pops"},   pop_cnt,  r_pop);
    check({tag, ".busy_cycles"}, n_busy, r_cyc);
    $display("run %s: done=%0d fail=%0d steps=%0d steps4=%0d pushes=%0d pops=%0d busy=%0d",
             tag, bus.done, bus.fail, bus.steps, bus4.steps, push_cnt, pop_cnt, n_busy);
  endtask

  task automatic release_start(input string tag);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check({tag, ".idle_outs"}, int'(outs), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit hit;
    int dens;
    rst = 1'b0;
    bus.start = 1'b0;
    load_maze_a();
    repeat (3) @(negedge clk);
    check("reset.outs", int'(outs), 0);
    check("reset.steps", int'(bus.steps), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle.outs", int'(outs), 0);

    // straight corridor down then right
    verify_run("A");
    check("A.steps_30", int'(bus.steps), 30);
    check("A.no_pops", pop_cnt, 0);
    check("A.steps4_sat", int'(bus4.steps), 15);

    // start held after done: no rerun
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold.done", int'(bus.done), 1);
      check("hold.busy", int'(bus.busy), 0);
    end
    release_start("hold");

    // rerun from a fresh maze; steps restart at 0
    load_maze_a();
    verify_run("A2");
    check("A2.steps_30", int'(bus.steps), 30);
    release_start("A2");

    // one dead end at (1,0)
    load_maze_a();
    maze_wall[1] = 1'b0;
    verify_run("B");
    check("B.steps_32", int'(bus.steps), 32);
    check("B.one_pop", pop_cnt, 1);
    check("B.pop_dir", last_pop, 1);
    release_start("B");

    // start cell boxed in
    load_all(1'b0);
    maze_wall[16] = 1'b1;
    maze_wall[1]  = 1'b1;
    verify_run("C");
    check("C.fail", int'(bus.fail), 1);
    check("C.steps_0", int'(bus.steps), 0);
    release_start("C");

    // reset while searching
    load_maze_a();
    clear_dp();
    bus.start = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (bus.steps >= 4 && bus.rd_mem) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst.reach_try", int'(hit), 1);
    #2;
    rst = 1'b0;
    bus.start = 1'b0;
    #1;
    check("rst.outs", int'(outs), 0);
    check("rst.steps", int'(bus.steps), 0);
    check("rst.steps4", int'(bus4.steps), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst.idle", int'(outs), 0);
    load_maze_a();
    verify_run("R");
    check("R.steps_30", int'(bus.steps), 30);
    release_start("R");

    // random mazes
    for (int t = 0; t < 16; t++) begin
      dens = $urandom_range(10, 45);
      for (int i = 0; i < 256; i++) maze_wall[i] = ($urandom_range(0, 99) < dens);
      maze_wall[0]   = 1'b0;
      maze_wall[255] = 1'b0;
      verify_run($sformatf("rnd%0d", t));
      release_start($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
